// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared types for the RV32M iterative multiply/divide unit.
//   multop_t    - funct3 encoding of the eight RV32M operations
//   mdu_state_t - control FSM states
//   XLEN, ROB_IDX_WIDTH - datapath and ROB tag widths
package mul_div_unit_pkg;

    localparam int XLEN          = 32;
    localparam int ROB_IDX_WIDTH = 5;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } multop_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } mdu_state_t;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic is_div_op(input multop_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: issue-side and result-side handshakes of the mul/div unit.
//   master - reservation station + CDB side (drives issue_*, out_ready)
//   slave  - the execute unit (drives issue_ready, out_*)
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once valid is raised, the source holds
// valid and its payload unchanged until that transfer edge; ready may be
// combinationally derived from the sink's state and the other channel.
interface mul_div_unit_if;
    import mul_div_unit_pkg::*;

    logic                     issue_valid;
    logic                     issue_ready;
    multop_t                  issue_multop;
    logic [XLEN-1:0]          issue_rs1;
    logic [XLEN-1:0]          issue_rs2;
    logic [4:0]               issue_rd_addr;
    logic [ROB_IDX_WIDTH-1:0] issue_rob_idx;

    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_data;
    logic [4:0]               out_rd_addr;
    logic [ROB_IDX_WIDTH-1:0] out_rob_idx;

    modport master (
        output issue_valid, issue_multop, issue_rs1, issue_rs2, issue_rd_addr, issue_rob_idx,
        output out_ready,
        input  issue_ready,
        input  out_valid, out_data, out_rd_addr, out_rob_idx
    );

    modport slave (
        input  issue_valid, issue_multop, issue_rs1, issue_rs2, issue_rd_addr, issue_rob_idx,
        input  out_ready,
        output issue_ready,
        output out_valid, out_data, out_rd_addr, out_rob_idx
    );

endinterface

// File: rtl/mul_div_unit_sign_fixup.sv
// mul_div_unit_sign_fixup: combinational sign handling around the unsigned
// iterative core.
//   pre-stage : i_pre_op, i_rs1, i_rs2 -> o_mag1/o_mag2 (operand magnitudes),
//               o_neg_q (negate product/quotient), o_neg_r (negate remainder)
//   post-stage: i_post_op, i_neg_q, i_neg_r, i_prod, i_quot, i_rem -> o_result
module mul_div_unit_sign_fixup
    import mul_div_unit_pkg::*;
(
    input  multop_t         i_pre_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_mag1,
    output logic [XLEN-1:0] o_mag2,
    output logic            o_neg_q,
    output logic            o_neg_r,

    input  multop_t         i_post_op,
    input  logic            i_neg_q,
    input  logic            i_neg_r,
    input  logic [63:0]     i_prod,
    input  logic [XLEN-1:0] i_quot,
    input  logic [XLEN-1:0] i_rem,
    output logic [XLEN-1:0] o_result
);

    logic        w_rs1_signed;
    logic        w_rs2_signed;
    logic        w_rs1_neg;
    logic        w_rs2_neg;
    logic [63:0] w_prod_s;

    always_comb begin
        w_rs1_signed = (i_pre_op != MULHU) && (i_pre_op != DIVU) && (i_pre_op != REMU);
        w_rs2_signed = (i_pre_op == MUL) || (i_pre_op == MULH) ||
                       (i_pre_op == DIV) || (i_pre_op == REM);
        w_rs1_neg    = w_rs1_signed & i_rs1[XLEN-1];
        w_rs2_neg    = w_rs2_signed & i_rs2[XLEN-1];
        // 32'h8000_0000 negates to itself, which is the correct unsigned magnitude.
        o_mag1       = w_rs1_neg ? (~i_rs1 + 32'd1) : i_rs1;
        o_mag2       = w_rs2_neg ? (~i_rs2 + 32'd1) : i_rs2;
        o_neg_q      = w_rs1_neg ^ w_rs2_neg;
        o_neg_r      = w_rs1_neg;
    end

    always_comb begin
        // The high half is only correct if the negation spans all 64 bits.
        w_prod_s = i_neg_q ? (~i_prod + 64'd1) : i_prod;
        case (i_post_op)
            MUL:                 o_result = w_prod_s[31:0];
            MULH, MULHSU, MULHU: o_result = w_prod_s[63:32];
            DIV, DIVU:           o_result = i_neg_q ? (~i_quot + 32'd1) : i_quot;
            default:             o_result = i_neg_r ? (~i_rem + 32'd1) : i_rem;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M execute unit between the mul/div reservation
// station and the CDB mul slot. One op at a time: radix-2 shift-add multiply
// or restoring divide, 32 iterations, result held until the CDB takes it.
//   clk, rst (async, active low), flush (kills in-flight op and held result)
//   mdu       - issue_* / out_* handshakes (slave side of mul_div_unit_if)
//   busy      - state != IDLE
//   dbg_state - current FSM state
module mul_div_unit
    import mul_div_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    mul_div_unit_if.slave mdu,
    output logic          busy,
    output mdu_state_t    dbg_state
);

    mdu_state_t               r_state;
    mdu_state_t               w_state_nx;
    mdu_state_t               w_launch_st;
    logic [4:0]               r_cnt;
    multop_t                  r_op;
    logic                     r_neg_q;
    logic                     r_neg_r;
    // Multiply: r_hi = partial product high half, r_lo = multiplier shifting out
    //           while product low bits shift in; r_opnd = multiplicand.
    // Divide:   r_hi = partial remainder, r_lo = dividend shifting out while
    //           quotient bits shift in; r_opnd = divisor.
    logic [XLEN-1:0]          r_hi;
    logic [XLEN-1:0]          r_lo;
    logic [XLEN-1:0]          r_opnd;
    logic [XLEN-1:0]          r_data;
    logic [4:0]               r_rd;
    logic [ROB_IDX_WIDTH-1:0] r_rob;

    logic                     w_accept;
    logic                     w_is_div;
    logic                     w_div0;
    logic                     w_ovf;
    logic                     w_special;
    logic                     w_last;
    logic                     w_running;
    logic [XLEN-1:0]          w_spec_data;
    logic [XLEN-1:0]          w_mag1;
    logic [XLEN-1:0]          w_mag2;
    logic                     w_neg_q;
    logic                     w_neg_r;
    logic [XLEN:0]            w_mul_sum;
    logic [XLEN:0]            w_div_shift;
    logic                     w_div_ge;
    logic [XLEN-1:0]          w_hi_nx;
    logic [XLEN-1:0]          w_lo_nx;
    logic [XLEN-1:0]          w_result;

    assign mdu.issue_ready = !flush && ((r_state == IDLE) || ((r_state == DONE) && mdu.out_ready));

    mul_div_unit_sign_fixup u_sign_fixup (
        .i_pre_op  (mdu.issue_multop),
        .i_rs1     (mdu.issue_rs1),
        .i_rs2     (mdu.issue_rs2),
        .o_mag1    (w_mag1),
        .o_mag2    (w_mag2),
        .o_neg_q   (w_neg_q),
        .o_neg_r   (w_neg_r),
        .i_post_op (r_op),
        .i_neg_q   (r_neg_q),
        .i_neg_r   (r_neg_r),
        .i_prod    ({w_hi_nx, w_lo_nx}),
        .i_quot    (w_lo_nx),
        .i_rem     (w_hi_nx),
        .o_result  (w_result)
    );

    // Issue decode, including the divide cases that bypass the iterations.
    always_comb begin
        w_accept  = mdu.issue_valid & mdu.issue_ready;
        w_is_div  = is_div_op(mdu.issue_multop);
        w_div0    = w_is_div && (mdu.issue_rs2 == '0);
        w_ovf     = ((mdu.issue_multop == DIV) || (mdu.issue_multop == REM)) &&
                    (mdu.issue_rs1 == 32'h8000_0000) && (mdu.issue_rs2 == '1);
        w_special = w_div0 | w_ovf;
        // funct3[1] selects REM/REMU over DIV/DIVU.
        if (w_div0) begin
            w_spec_data = mdu.issue_multop[1] ? mdu.issue_rs1 : '1;
        end else begin
            w_spec_data = mdu.issue_multop[1] ? '0 : 32'h8000_0000;
        end
        if (w_special) begin
            w_launch_st = DONE;
        end else if (w_is_div) begin
            w_launch_st = DIV_RUN;
        end else begin
            w_launch_st = MUL_RUN;
        end
    end

    // One iteration of the shared shift datapath.
    always_comb begin
        w_running   = (r_state == MUL_RUN) || (r_state == DIV_RUN);
        w_last      = (r_cnt == 5'd31);
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_hi, r_lo[XLEN-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        if (r_state == MUL_RUN) begin
            w_hi_nx = w_mul_sum[XLEN:1];
            w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end else begin
            // When the subtraction succeeds the difference is below the divisor,
            // so dropping the top bit of the shifted remainder is exact.
            w_hi_nx = w_div_ge ? (w_div_shift[XLEN-1:0] - r_opnd) : w_div_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], w_div_ge};
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            MUL_RUN, DIV_RUN: if (w_last) w_state_nx = DONE;
            DONE:             if (mdu.out_ready) w_state_nx = IDLE;
            default:          w_state_nx = r_state;
        endcase
        if (w_accept) w_state_nx = w_launch_st;
        if (flush)    w_state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_op    <= MUL;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
            r_rob   <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= mdu.issue_multop;
            r_neg_q <= w_neg_q;
            r_neg_r <= w_neg_r;
            r_rd    <= mdu.issue_rd_addr;
            r_rob   <= mdu.issue_rob_idx;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_mag1 : w_mag2;
            r_opnd  <= w_is_div ? w_mag2 : w_mag1;
            if (w_special) r_data <= w_spec_data;
        end else if (w_running && !flush) begin
            r_cnt <= r_cnt + 5'd1;
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            // The result is formed from the final iteration's values directly,
            // so it lands in r_data on the same edge that enters DONE.
            if (w_last) r_data <= w_result;
        end
    end

    assign mdu.out_valid   = (r_state == DONE);
    assign mdu.out_data    = r_data;
    assign mdu.out_rd_addr = r_rd;
    assign mdu.out_rob_idx = r_rob;
    assign busy            = (r_state != IDLE);
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       busy;
    mdu_state_t dbg_state;

    mul_div_unit_if mdu();

    mul_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .mdu       (mdu),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [9:0]  exp_tag_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; v = p; return v[31:0]; end
            3'd1: begin p = sa * sb; v = p; return v[63:32]; end
            3'd2: begin p = sa * $signed({32'd0, b}); v = p; return v[63:32]; end
            3'd3: begin v = {32'd0, a} * {32'd0, b}; return v[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; v = p; return v[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; v = p; return v[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd, input logic [4:0] rob);
        mdu.issue_valid   = 1'b1;
        mdu.issue_multop  = multop_t'(op);
        mdu.issue_rs1     = a;
        mdu.issue_rs2     = b;
        mdu.issue_rd_addr = rd;
        mdu.issue_rob_idx = rob;
    endtask

    // Returns #1 after the accept edge.
    task automatic drive_issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [4:0] rob);
        int waits;
        @(negedge clk);
        set_issue(op, a, b, rd, rob);
        waits = 0;
        while (!mdu.issue_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        check("issue_ready_seen", 64'(mdu.issue_ready), 64'd1);
        @(posedge clk);
        #1;
        mdu.issue_valid = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the accept edge.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!mdu.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        mdu.out_ready = 1'b1;
        @(posedge clk);
        #1;
        mdu.out_ready = 1'b0;
        check("retire_valid_low", 64'(mdu.out_valid), 64'd0);
        check("retire_busy_low", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input int exp_lat);
        logic [4:0]  rd;
        logic [4:0]  rob;
        logic [31:0] e_data;
        logic [9:0]  e_tag;
        int          lat;
        rd  = 5'($urandom_range(0, 31));
        rob = 5'($urandom_range(0, 31));
        exp_q.push_back(exp_data);
        exp_tag_q.push_back({rd, rob});
        drive_issue(op, a, b, rd, rob);
        wait_result(lat);
        e_data = exp_q.pop_front();
        e_tag  = exp_tag_q.pop_front();
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, 64'(mdu.out_data), 64'(e_data));
        check({tag, "_tags"}, 64'({mdu.out_rd_addr, mdu.out_rob_idx}), 64'(e_tag));
        retire();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          lat;
        int          hits;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b0;
        flush = 1'b0;
        mdu.issue_valid = 1'b0;
        mdu.issue_multop = MUL;
        mdu.issue_rs1 = '0;
        mdu.issue_rs2 = '0;
        mdu.issue_rd_addr = '0;
        mdu.issue_rob_idx = '0;
        mdu.out_ready = 1'b0;

        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(mdu.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(mdu.out_data), 64'd0);
        check("rst_tags", 64'({mdu.out_rd_addr, mdu.out_rob_idx}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors with hand-derived results.
        run_op("mul_7_m3",        3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_ff_ff",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_min_min",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu_ff_ff",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2",        3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",        3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu_100_7",      3'd5, 32'd100,        32'd7,         32'd14,        33);
        run_op("remu_100_7",      3'd7, 32'd100,        32'd7,         32'd2,         33);
        run_op("div_by0",         3'd4, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1);
        run_op("divu_by0",        3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_5_by0",       3'd6, 32'd5,          32'd0,         32'd5,         1);
        run_op("remu_5_by0",      3'd7, 32'd5,          32'd0,         32'd5,         1);
        run_op("div_ovf",         3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",         3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_op("remu_min_ff",     3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_model(op, a, b), ref_latency(op, a, b));
        end

        // Result held while the CDB stalls, then back-to-back retire + accept.
        drive_issue(3'd0, 32'd123, 32'd456, 5'd3, 5'd9);
        wait_result(lat);
        check("hold_lat", 64'(lat), 64'd33);
        set_issue(3'd5, 32'd1000, 32'd7, 5'd4, 5'd10);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(mdu.out_valid), 64'd1);
            check("hold_data", 64'(mdu.out_data), 64'h0000_DB18);
            check("hold_tags", 64'({mdu.out_rd_addr, mdu.out_rob_idx}), 64'({5'd3, 5'd9}));
            check("hold_issue_ready", 64'(mdu.issue_ready), 64'd0);
        end
        mdu.out_ready = 1'b1;
        #1;
        check("b2b_issue_ready", 64'(mdu.issue_ready), 64'd1);
        @(posedge clk);
        #1;
        mdu.out_ready = 1'b0;
        mdu.issue_valid = 1'b0;
        check("b2b_state", 64'(dbg_state), 64'(DIV_RUN));
        check("b2b_valid_low", 64'(mdu.out_valid), 64'd0);
        wait_result(lat);
        check("b2b_lat", 64'(lat), 64'd33);
        check("b2b_data", 64'(mdu.out_data), 64'd142);
        check("b2b_tags", 64'({mdu.out_rd_addr, mdu.out_rob_idx}), 64'({5'd4, 5'd10}));
        retire();

        // Flush during DIV_RUN.
        drive_issue(3'd4, 32'd1000, 32'd3, 5'd1, 5'd2);
        repeat (14) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_run_state", 64'(dbg_state), 64'(IDLE));
        check("flush_run_busy", 64'(busy), 64'd0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (mdu.out_valid) hits++;
        end
        check("flush_no_valid", 64'(hits), 64'd0);
        run_op("after_flush_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);

        // Flush in DONE dominates out_ready and a pending issue.
        drive_issue(3'd0, 32'd3, 32'd5, 5'd6, 5'd7);
        wait_result(lat);
        check("flush_done_valid", 64'(mdu.out_valid), 64'd1);
        flush = 1'b1;
        mdu.out_ready = 1'b1;
        set_issue(3'd0, 32'd2, 32'd2, 5'd8, 5'd8);
        #1;
        check("flush_issue_ready", 64'(mdu.issue_ready), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        mdu.out_ready = 1'b0;
        mdu.issue_valid = 1'b0;
        check("flush_done_out_valid", 64'(mdu.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("flush_dropped_state", 64'(dbg_state), 64'(IDLE));

        // Reset mid-MUL_RUN clears outputs without waiting for a clock.
        drive_issue(3'd0, 32'h1234, 32'h5678, 5'd7, 5'd11);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_valid", 64'(mdu.out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data", 64'(mdu.out_data), 64'd0);
        check("midrst_tags", 64'({mdu.out_rd_addr, mdu.out_rob_idx}), 64'd0);
        check("midrst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst_mulhu", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 33);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
